// File: rtl/kronos_dmem.sv
// Word-organised data memory slave with byte-lane writes and a req/ack handshake.
// Optional range checking is enabled by defining KRONOS_DMEM_RANGE_CHECK_EN.
module kronos_dmem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  output logic [31:0] data_rd_data,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic        data_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rd_q;

  logic [31:0] mem [DEPTH];

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          hit;
  logic          accept;
  logic          wr_fire;
  logic          err_d;
  logic [31:0]   rd_data_d;
  logic          unused_addr;

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
  function automatic logic addr_in_range(input logic [31:0] off);
    return off < SPAN;
  endfunction

  assign offset      = data_addr - BASE_ADDR;
  assign idx         = offset[AW+1:2];
  assign in_range    = addr_in_range(offset);
  assign unused_addr = ^{offset[1:0], offset[31:AW+2]};

`ifdef KRONOS_DMEM_RANGE_CHECK_EN
  assign hit   = in_range;
  assign err_d = ~in_range;
`else
  logic unused_range;
  assign unused_range = in_range;
  assign hit          = 1'b1;
  assign err_d        = 1'b0;
`endif

  // accept marks the edge on which the access enters ACK and is committed.
  always_comb begin
    accept = 1'b0;
    case (state_q)
      IDLE:    accept = data_req && (WAIT_CYCLES == 0);
      WAIT:    accept = data_req && (cnt_q == 4'd1);
      default: accept = 1'b0;
    endcase
  end

  assign wr_fire   = accept && data_wr_en && hit && rstz;
  assign rd_data_d = data_wr_en ? rd_q : (hit ? mem[idx] : 32'h0);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wr_mask[b]) mem[idx][8*b +: 8] <= data_wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (accept) begin
        ack_q <= 1'b1;
        err_q <= err_d;
        rd_q  <= rd_data_d;
      end
      case (state_q)
        IDLE: begin
          if (data_req) begin
            if (WAIT_CYCLES == 0) begin
              state_q <= ACK;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (!data_req) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_q <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_ack     = ack_q;
  assign data_err     = err_q;
  assign data_rd_data = rd_q;

endmodule

// File: tb/tb_kronos_dmem.sv
// Directed bench for kronos_dmem: one zero-wait instance and one three-wait instance.
module tb_kronos_dmem;

  logic clk;
  logic rstz;

  logic [31:0] a0, wd0, rd0;
  logic [3:0]  m0;
  logic        we0, req0, ack0, err0;
  logic [31:0] a3, wd3, rd3;
  logic [3:0]  m3;
  logic        we3, req3, ack3, err3;

  kronos_dmem #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rstz(rstz), .data_addr(a0), .data_rd_data(rd0), .data_wr_data(wd0),
    .data_wr_mask(m0), .data_wr_en(we0), .data_req(req0), .data_ack(ack0), .data_err(err0)
  );

  kronos_dmem #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rstz(rstz), .data_addr(a3), .data_rd_data(rd3), .data_wr_data(wd3),
    .data_wr_mask(m3), .data_wr_en(we3), .data_req(req3), .data_ack(ack3), .data_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm[int];
  logic [31:0] last_rd[2];
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: word index modulo DEPTH, out-of-range handling chosen by the build macro.
  function automatic exp_t model_access(input int sel, input logic [31:0] a, input logic we,
                                        input logic [31:0] wd, input logic [3:0] m);
    exp_t        e;
    logic        inr;
    int          key;
    logic [31:0] w;
    inr = (a < 32'(4 * 1024));
    key = sel * 1024 + int'((a >> 2) % 1024);
    e.lat = 32'd0;
    e.err = 1'b0;
`ifdef KRONOS_DMEM_RANGE_CHECK_EN
    if (!inr) begin
      e.err = 1'b1;
      if (!we) last_rd[sel] = 32'h0;
      e.rd = last_rd[sel];
      return e;
    end
`endif
    if (we) begin
      w = mm.exists(key) ? mm[key] : 32'hxxxx_xxxx;
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
      mm[key] = w;
    end else begin
      last_rd[sel] = mm[key];
    end
    e.rd = last_rd[sel];
    return e;
  endfunction

  task automatic drive(input int sel, input logic rq, input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] m);
    if (sel == 0) begin
      req0 = rq; a0 = a; we0 = we; wd0 = wd; m0 = m;
    end else begin
      req3 = rq; a3 = a; we3 = we; wd3 = wd; m3 = m;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    chk("idle_ack0", {31'd0, ack0}, 32'd0);
    chk("idle_err0", {31'd0, err0}, 32'd0);
    chk("idle_ack3", {31'd0, ack3}, 32'd0);
    chk("idle_err3", {31'd0, err3}, 32'd0);
  endtask

  // Drives one access, waits (bounded) for its ack, compares latency/data/err.
  task automatic access(input int sel, input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [3:0] m, input int lat_exp, output logic [31:0] rd_obs);
    exp_t        e;
    int          n;
    logic        ackv;
    logic        errv;
    logic [31:0] rdv;
    e     = model_access(sel, a, we, wd, m);
    e.lat = 32'(lat_exp);
    sb.push_back(e);
    drive(sel, 1'b1, a, we, wd, m);
    n    = 0;
    ackv = 1'b0;
    errv = 1'b0;
    rdv  = 32'h0;
    while (!ackv && n < 40) begin
      @(negedge clk);
      n++;
      ackv = (sel == 0) ? ack0 : ack3;
      errv = (sel == 0) ? err0 : err3;
      rdv  = (sel == 0) ? rd0 : rd3;
    end
    drive(sel, 1'b0, a, we, wd, m);
    e = sb.pop_front();
    chk("latency", 32'(n), e.lat);
    chk("rd_data", rdv, e.rd);
    chk("err", {31'd0, errv}, {31'd0, e.err});
    rd_obs = rdv;
  endtask

  logic [31:0] r;

  initial begin
    total = 0;
    bad   = 0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    rstz = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_rd3", rd3, 32'h0);
    rstz = 1'b1;

    // Zero-wait instance: basic write/read and byte-lane masking.
    idle(); access(0, 32'h10, 1'b1, 32'h1234_5678, 4'hF, 1, r);
    idle(); access(0, 32'h10, 1'b0, 32'h0, 4'h0, 1, r);
    chk("rd_0x10", r, 32'h1234_5678);
    idle(); access(0, 32'h20, 1'b1, 32'hAABB_CCDD, 4'hF, 1, r);
    idle(); access(0, 32'h20, 1'b1, 32'h0000_1100, 4'b0010, 1, r);
    idle(); access(0, 32'h20, 1'b0, 32'h0, 4'hF, 1, r);
    chk("rd_masked", r, 32'hAABB_11DD);
    idle(); access(0, 32'h20, 1'b1, 32'hFFFF_FFFF, 4'h0, 1, r);
    idle(); access(0, 32'h23, 1'b0, 32'h0, 4'h0, 1, r);
    chk("rd_mask0", r, 32'hAABB_11DD);

    // Back-to-back reads: second request raised in the first ack cycle.
    idle(); access(0, 32'h04, 1'b1, 32'h0404_0404, 4'hF, 1, r);
    idle(); access(0, 32'h08, 1'b1, 32'h0808_0808, 4'hF, 1, r);
    idle(); access(0, 32'h00, 1'b1, 32'hCAFE_F00D, 4'hF, 1, r);
    idle(); access(0, 32'h04, 1'b0, 32'h0, 4'h0, 1, r);
    access(0, 32'h08, 1'b0, 32'h0, 4'h0, 2, r);
    chk("rd_b2b", r, 32'h0808_0808);

    // Range boundary: last word, one past the end, and an out-of-range write.
    idle(); access(0, 32'hFFC, 1'b1, 32'h0FFC_0FFC, 4'hF, 1, r);
    idle(); access(0, 32'hFFC, 1'b0, 32'h0, 4'h0, 1, r);
    idle(); access(0, 32'h1000, 1'b0, 32'h0, 4'h0, 1, r);
    idle(); access(0, 32'h1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 1, r);
    idle(); access(0, 32'h04, 1'b0, 32'h0, 4'h0, 1, r);

    // Three-wait instance: latency, then an aborted write.
    idle(); access(1, 32'h40, 1'b1, 32'h1111_2222, 4'hF, 4, r);
    idle(); access(1, 32'h40, 1'b0, 32'h0, 4'h0, 4, r);
    idle();
    drive(1, 1'b1, 32'h40, 1'b1, 32'h9999_9999, 4'hF);
    @(negedge clk);
    chk("abort_ack_a", {31'd0, ack3}, 32'd0);
    @(negedge clk);
    drive(1, 1'b0, 32'h40, 1'b1, 32'h9999_9999, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_noack", {31'd0, ack3}, 32'd0);
    end
    idle(); access(1, 32'h40, 1'b0, 32'h0, 4'h0, 4, r);
    chk("abort_keep", r, 32'h1111_2222);

    // Reset pulse while a write waits: outputs clear at once, word keeps old value.
    idle(); access(0, 32'h10, 1'b0, 32'h0, 4'h0, 1, r);
    idle();
    drive(1, 1'b1, 32'h40, 1'b1, 32'h5555_5555, 4'hF);
    @(negedge clk);
    #1 rstz = 1'b0;
    #1;
    chk("rstw_ack3", {31'd0, ack3}, 32'd0);
    chk("rstw_err3", {31'd0, err3}, 32'd0);
    chk("rstw_rd3", rd3, 32'h0);
    chk("rstw_rd0", rd0, 32'h0);
    @(negedge clk);
    drive(1, 1'b0, 32'h40, 1'b1, 32'h5555_5555, 4'hF);
    rstz = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    idle(); access(1, 32'h40, 1'b0, 32'h0, 4'h0, 4, r);
    chk("rstw_keep", r, 32'h1111_2222);
    idle(); access(0, 32'h10, 1'b0, 32'h0, 4'h0, 1, r);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
